// File: rtl/temporizador_contagem.sv
// -----------------------------------------------------------------------------
// temporizador_contagem
// BCD MM:SS countdown timer for the microwave controller. Keypad digits shift
// into the display from the right. iniciar starts or resumes the count and
// cancelar pauses or clears it. An open door pauses the count. On reaching
// 00:00 the block pulses fim and holds som high for BEEP_SEG seconds.
//
// Parameters:
//   TICK_DIV  clock cycles per second (>= 2)
//   BEEP_SEG  seconds som stays high after 00:00 (>= 1)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tecla_valida_i      one-cycle strobe, tecla_i holds a new key
//   tecla_i[3:0]        key value, 0-9 digits, 10-15 ignored
//   iniciar_i           one-cycle start/resume strobe
//   cancelar_i          one-cycle pause/clear strobe
//   porta_i             door open (level)
//   min_dez_o..seg_uni_o  BCD digits MM:SS
//   rodando_o           registered, high while counting
//   luz_o               lamp, door open or counting
//   som_o               beeper
//   fim_o               one-cycle pulse when the count reaches 00:00
//
// Optional feature: define INICIO_RAPIDO_EN to enable quick start. iniciar at
// 00:00 loads 00:30, and iniciar while running adds 30 s, saturating at 99:59.
// -----------------------------------------------------------------------------
// state    | meaning
// ST_IDLE  | digit entry, waiting for iniciar
// ST_RUN   | counting down, motor and heater on
// ST_PAUSE | count frozen (door or cancelar), prescaler held
// ST_DONE  | reached 00:00, beeping for BEEP_SEG seconds
// -----------------------------------------------------------------------------
module temporizador_contagem #(
    parameter int TICK_DIV = 1000,
    parameter int BEEP_SEG = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tecla_valida_i,
    input  logic [3:0] tecla_i,
    input  logic       iniciar_i,
    input  logic       cancelar_i,
    input  logic       porta_i,
    output logic [3:0] min_dez_o,
    output logic [3:0] min_uni_o,
    output logic [3:0] seg_dez_o,
    output logic [3:0] seg_uni_o,
    output logic       rodando_o,
    output logic       luz_o,
    output logic       som_o,
    output logic       fim_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BEEP_SEG + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_INI  = BW'(BEEP_SEG);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } estado_t;

    estado_t       state_q, state_d;
    logic [3:0]    md_q, mu_q, sd_q, su_q;
    logic [3:0]    md_d, mu_d, sd_d, su_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] beep_q, beep_d;
    logic          rodando_q, som_q, som_d, fim_q, fim_d;

    logic          tick;
    logic          tempo_zero;
    logic          digito_ok;
    logic [3:0]    dec_md, dec_mu, dec_sd, dec_su;
    logic          dec_zero;

    assign tick       = (presc_q == PRESC_MAX);
    assign tempo_zero = ({md_q, mu_q, sd_q, su_q} == 16'd0);
    assign digito_ok  = tecla_valida_i && (tecla_i <= 4'd9);

    // One-second BCD decrement. It is only used while the time is nonzero,
    // so the all-zero fall-through never reaches the registers.
    always_comb begin
        dec_md = md_q;
        dec_mu = mu_q;
        dec_sd = sd_q;
        dec_su = su_q;
        if (su_q != 4'd0) begin
            dec_su = su_q - 4'd1;
        end else if (sd_q != 4'd0) begin
            dec_sd = sd_q - 4'd1;
            dec_su = 4'd9;
        end else if (mu_q != 4'd0) begin
            dec_mu = mu_q - 4'd1;
            dec_sd = 4'd5;
            dec_su = 4'd9;
        end else begin
            dec_md = md_q - 4'd1;
            dec_mu = 4'd9;
            dec_sd = 4'd5;
            dec_su = 4'd9;
        end
    end

    assign dec_zero = ({dec_md, dec_mu, dec_sd, dec_su} == 16'd0);

`ifdef INICIO_RAPIDO_EN
    // +30 s applies on top of any decrement that happens in the same cycle.
    // Seconds may hold up to 99, so the sum can carry up to two minutes.
    logic [3:0] base_md, base_mu, base_sd, base_su;
    logic [3:0] add_md, add_mu, add_sd, add_su;
    logic [7:0] seg_bin, min_bin, dig_t;

    assign base_md = tick ? dec_md : md_q;
    assign base_mu = tick ? dec_mu : mu_q;
    assign base_sd = tick ? dec_sd : sd_q;
    assign base_su = tick ? dec_su : su_q;

    always_comb begin
        seg_bin = {4'd0, base_sd} * 8'd10 + {4'd0, base_su} + 8'd30;
        min_bin = {4'd0, base_md} * 8'd10 + {4'd0, base_mu};
        if (seg_bin >= 8'd120) begin
            seg_bin = seg_bin - 8'd120;
            min_bin = min_bin + 8'd2;
        end else if (seg_bin >= 8'd60) begin
            seg_bin = seg_bin - 8'd60;
            min_bin = min_bin + 8'd1;
        end
        if (min_bin > 8'd99) begin
            min_bin = 8'd99;
            seg_bin = 8'd59;
        end
        dig_t  = min_bin / 8'd10;
        add_md = dig_t[3:0];
        dig_t  = min_bin % 8'd10;
        add_mu = dig_t[3:0];
        dig_t  = seg_bin / 8'd10;
        add_sd = dig_t[3:0];
        dig_t  = seg_bin % 8'd10;
        add_su = dig_t[3:0];
    end
`endif

    always_comb begin
        state_d = state_q;
        md_d    = md_q;
        mu_d    = mu_q;
        sd_d    = sd_q;
        su_d    = su_q;
        presc_d = presc_q;
        beep_d  = beep_q;
        som_d   = som_q;
        fim_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cancelar_i) begin
                    md_d = 4'd0;
                    mu_d = 4'd0;
                    sd_d = 4'd0;
                    su_d = 4'd0;
                end else if (iniciar_i) begin
                    if (!porta_i && !tempo_zero) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
`ifdef INICIO_RAPIDO_EN
                    else if (!porta_i) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                        sd_d    = 4'd3;
                        su_d    = 4'd0;
                    end
`endif
                end else if (digito_ok) begin
                    md_d = mu_q;
                    mu_d = sd_q;
                    sd_d = su_q;
                    su_d = tecla_i;
                end
            end

            ST_RUN: begin
                // The final decrement wins over a door opening or cancel in
                // the same cycle.
                if (tick && dec_zero) begin
                    state_d = ST_DONE;
                    md_d    = 4'd0;
                    mu_d    = 4'd0;
                    sd_d    = 4'd0;
                    su_d    = 4'd0;
                    presc_d = '0;
                    fim_d   = 1'b1;
                    som_d   = 1'b1;
                    beep_d  = BEEP_INI;
                end else if (porta_i || cancelar_i) begin
                    state_d = ST_PAUSE;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
`ifdef INICIO_RAPIDO_EN
                    if (iniciar_i) begin
                        md_d = add_md;
                        mu_d = add_mu;
                        sd_d = add_sd;
                        su_d = add_su;
                    end else if (tick) begin
                        md_d = dec_md;
                        mu_d = dec_mu;
                        sd_d = dec_sd;
                        su_d = dec_su;
                    end
`else
                    if (tick) begin
                        md_d = dec_md;
                        mu_d = dec_mu;
                        sd_d = dec_sd;
                        su_d = dec_su;
                    end
`endif
                end
            end

            ST_PAUSE: begin
                if (cancelar_i) begin
                    state_d = ST_IDLE;
                    md_d    = 4'd0;
                    mu_d    = 4'd0;
                    sd_d    = 4'd0;
                    su_d    = 4'd0;
                end else if (iniciar_i && !porta_i) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick && (beep_q != '0)) begin
                    beep_d = beep_q - BW'(1);
                    if (beep_q == BW'(1)) begin
                        som_d = 1'b0;
                    end
                end
                if (cancelar_i || iniciar_i) begin
                    state_d = ST_IDLE;
                    som_d   = 1'b0;
                end else if (digito_ok) begin
                    state_d = ST_IDLE;
                    som_d   = 1'b0;
                    md_d    = 4'd0;
                    mu_d    = 4'd0;
                    sd_d    = 4'd0;
                    su_d    = tecla_i;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            md_q      <= 4'd0;
            mu_q      <= 4'd0;
            sd_q      <= 4'd0;
            su_q      <= 4'd0;
            presc_q   <= '0;
            beep_q    <= '0;
            rodando_q <= 1'b0;
            som_q     <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_q      <= md_d;
            mu_q      <= mu_d;
            sd_q      <= sd_d;
            su_q      <= su_d;
            presc_q   <= presc_d;
            beep_q    <= beep_d;
            rodando_q <= (state_d == ST_RUN);
            som_q     <= som_d;
            fim_q     <= fim_d;
        end
    end

    assign min_dez_o = md_q;
    assign min_uni_o = mu_q;
    assign seg_dez_o = sd_q;
    assign seg_uni_o = su_q;
    assign rodando_o = rodando_q;
    assign som_o     = som_q;
    assign fim_o     = fim_q;
    assign luz_o     = porta_i || (state_q == ST_RUN);

endmodule

// File: tb/tb_temporizador_contagem.sv
// -----------------------------------------------------------------------------
// tb_temporizador_contagem
// Bench for temporizador_contagem with TICK_DIV=4 and BEEP_SEG=3. Expected
// times come from a minutes/seconds integer model and a digit-shift queue.
// Build with INICIO_RAPIDO_EN defined to exercise quick start.
// -----------------------------------------------------------------------------
module tb_temporizador_contagem;

    localparam int TICK = 4;
    localparam int BEEP = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tecla_valida = 1'b0;
    logic [3:0] tecla = 4'd0;
    logic       iniciar = 1'b0;
    logic       cancelar = 1'b0;
    logic       porta = 1'b0;
    logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
    logic       rodando, luz, som, fim;

    int n_tests = 0;
    int n_fail  = 0;

    wire [15:0] disp = {min_dez, min_uni, seg_dez, seg_uni};

    temporizador_contagem #(.TICK_DIV(TICK), .BEEP_SEG(BEEP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tecla_valida_i (tecla_valida),
        .tecla_i        (tecla),
        .iniciar_i      (iniciar),
        .cancelar_i     (cancelar),
        .porta_i        (porta),
        .min_dez_o      (min_dez),
        .min_uni_o      (min_uni),
        .seg_dez_o      (seg_dez),
        .seg_uni_o      (seg_uni),
        .rodando_o      (rodando),
        .luz_o          (luz),
        .som_o          (som),
        .fim_o          (fim)
    );

    always #5 clk = ~clk;

    // Display image of a minutes/seconds pair.
    function automatic logic [15:0] bcd(input int m, input int s);
        logic [3:0] a, b, c, d;
        a = 4'(m / 10);
        b = 4'(m % 10);
        c = 4'(s / 10);
        d = 4'(s % 10);
        return {a, b, c, d};
    endfunction

    // Quick-start addition expressed as total seconds with minute carry.
    function automatic logic [15:0] add30(input int m, input int s);
        int t, mm, ss;
        t  = s + 30;
        mm = m + t / 60;
        ss = t % 60;
        if (mm > 99) begin
            mm = 99;
            ss = 59;
        end
        return bcd(mm, ss);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_key(input int d);
        tecla        = 4'(d);
        tecla_valida = 1'b1;
        step(1);
        tecla_valida = 1'b0;
    endtask

    task automatic pulse_iniciar;
        iniciar = 1'b1;
        step(1);
        iniciar = 1'b0;
    endtask

    task automatic pulse_cancelar;
        cancelar = 1'b1;
        step(1);
        cancelar = 1'b0;
    endtask

    // Two cancels reach a cleared IDLE from any state.
    task automatic enter_time(input int m, input int s);
        pulse_cancelar;
        pulse_cancelar;
        press_key(m / 10);
        press_key(m % 10);
        press_key(s / 10);
        press_key(s % 10);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        n_tests++;
        if (disp !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_digits got %h exp 0000", disp);
        end
        n_tests++;
        if ({rodando, som, fim, luz} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 0000", {rodando, som, fim, luz});
        end
        porta = 1'b1;
        #1;
        n_tests++;
        if (luz !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_luz_door got %b exp 1", luz);
        end
        porta = 1'b0;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_entry;
        int q[$];
        logic [15:0] exp;
        int keys[3] = '{1, 3, 0};
        q = {0, 0, 0, 0};
        pulse_cancelar;
        foreach (keys[i]) begin
            press_key(keys[i]);
            q.push_back(keys[i]);
            void'(q.pop_front());
        end
        exp = {4'(q[0]), 4'(q[1]), 4'(q[2]), 4'(q[3])};
        n_tests++;
        if (disp !== exp) begin
            n_fail++;
            $display("FAIL entry_130 got %h exp %h", disp, exp);
        end
        n_tests++;
        if ({rodando, luz} !== 2'b00) begin
            n_fail++;
            $display("FAIL entry_flags got %b exp 00", {rodando, luz});
        end
        press_key(12);
        n_tests++;
        if (disp !== exp) begin
            n_fail++;
            $display("FAIL entry_key12 got %h exp %h", disp, exp);
        end
        pulse_cancelar;
        n_tests++;
        if (disp !== 16'h0000) begin
            n_fail++;
            $display("FAIL entry_cancel got %h exp 0000", disp);
        end
    endtask

    task automatic test_countdown_basic;
        int cnt;
        enter_time(0, 2);
        pulse_iniciar;
        n_tests++;
        if (rodando !== 1'b1) begin
            n_fail++;
            $display("FAIL cd_rodando got %b exp 1", rodando);
        end
        step(TICK - 1);
        n_tests++;
        if (disp !== bcd(0, 2)) begin
            n_fail++;
            $display("FAIL cd_early got %h exp %h", disp, bcd(0, 2));
        end
        step(1);
        n_tests++;
        if (disp !== bcd(0, 1)) begin
            n_fail++;
            $display("FAIL cd_1s got %h exp %h", disp, bcd(0, 1));
        end
        step(TICK);
        n_tests++;
        if ({disp, fim, som, rodando} !== {16'h0000, 3'b110}) begin
            n_fail++;
            $display("FAIL cd_end got %h/%b exp 0000/110", disp, {fim, som, rodando});
        end
        cnt = 1;
        step(1);
        n_tests++;
        if (fim !== 1'b0) begin
            n_fail++;
            $display("FAIL cd_fim_pulse got %b exp 0", fim);
        end
        while (som === 1'b1 && cnt < 100) begin
            cnt++;
            step(1);
        end
        n_tests++;
        if (cnt != BEEP * TICK) begin
            n_fail++;
            $display("FAIL cd_som_len got %0d exp %0d", cnt, BEEP * TICK);
        end
        press_key(7);
        n_tests++;
        if ({disp, rodando, som} !== {bcd(0, 7), 2'b00}) begin
            n_fail++;
            $display("FAIL cd_done_key got %h exp %h", disp, bcd(0, 7));
        end
    endtask

    task automatic test_borrow;
        enter_time(1, 0);
        pulse_iniciar;
        step(TICK);
        n_tests++;
        if (disp !== bcd(0, 59)) begin
            n_fail++;
            $display("FAIL borrow_min got %h exp %h", disp, bcd(0, 59));
        end
        enter_time(0, 90);
        pulse_iniciar;
        step(TICK);
        n_tests++;
        if (disp !== bcd(0, 89)) begin
            n_fail++;
            $display("FAIL borrow_90 got %h exp %h", disp, bcd(0, 89));
        end
    endtask

    task automatic test_pause;
        enter_time(0, 5);
        pulse_iniciar;
        n_tests++;
        if (luz !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_luz_run got %b exp 1", luz);
        end
        step(2);
        porta = 1'b1;
        step(1);
        n_tests++;
        if ({rodando, luz, disp} !== {2'b01, bcd(0, 5)}) begin
            n_fail++;
            $display("FAIL pause_enter got %b/%h exp 01/%h", {rodando, luz}, disp, bcd(0, 5));
        end
        step(10);
        n_tests++;
        if (disp !== bcd(0, 5)) begin
            n_fail++;
            $display("FAIL pause_frozen got %h exp %h", disp, bcd(0, 5));
        end
        pulse_iniciar;
        n_tests++;
        if (rodando !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_door_open_start got %b exp 0", rodando);
        end
        porta = 1'b0;
        #1;
        n_tests++;
        if (luz !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_luz_closed got %b exp 0", luz);
        end
        pulse_iniciar;
        n_tests++;
        if (rodando !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_resume got %b exp 1", rodando);
        end
        // Two running cycles were spent before the pause, two remain.
        step(1);
        n_tests++;
        if (disp !== bcd(0, 5)) begin
            n_fail++;
            $display("FAIL pause_partial_a got %h exp %h", disp, bcd(0, 5));
        end
        step(1);
        n_tests++;
        if (disp !== bcd(0, 4)) begin
            n_fail++;
            $display("FAIL pause_partial_b got %h exp %h", disp, bcd(0, 4));
        end
    endtask

    task automatic test_priority;
        enter_time(0, 5);
        pulse_iniciar;
        porta = 1'b1;
        step(1);
        porta    = 1'b0;
        cancelar = 1'b1;
        iniciar  = 1'b1;
        step(1);
        cancelar = 1'b0;
        iniciar  = 1'b0;
        n_tests++;
        if ({disp, rodando} !== {16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_cancel got %h/%b exp 0000/0", disp, rodando);
        end
        press_key(4);
        press_key(12);
        n_tests++;
        if (disp !== bcd(0, 4)) begin
            n_fail++;
            $display("FAIL prio_idle_keys got %h exp %h", disp, bcd(0, 4));
        end
        pulse_iniciar;
        press_key(3);
        step(TICK - 1);
        n_tests++;
        if (disp !== bcd(0, 3)) begin
            n_fail++;
            $display("FAIL prio_run_key got %h exp %h", disp, bcd(0, 3));
        end
    endtask

    task automatic test_random_countdown;
        for (int it = 0; it < 6; it++) begin
            int m, s;
            m = int'($urandom_range(0, 1));
            s = int'($urandom_range(0, 99));
            if (m == 0 && s == 0) s = 1;
            enter_time(m, s);
            n_tests++;
            if (disp !== bcd(m, s)) begin
                n_fail++;
                $display("FAIL rnd_load got %h exp %h", disp, bcd(m, s));
            end
            pulse_iniciar;
            while (!(m == 0 && s == 0)) begin
                step(TICK);
                if (s > 0) s--;
                else begin
                    m--;
                    s = 59;
                end
                n_tests++;
                if ({disp, fim} !== {bcd(m, s), (m == 0 && s == 0)}) begin
                    n_fail++;
                    $display("FAIL rnd_count got %h/%b exp %h", disp, fim, bcd(m, s));
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                step(int'($urandom_range(1, 8)));
                pulse_cancelar;
                n_tests++;
                if ({som, rodando} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL rnd_cancel_beep got %b exp 00", {som, rodando});
                end
            end else begin
                step(BEEP * TICK - 1);
                n_tests++;
                if (som !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_beep_hold got %b exp 1", som);
                end
                step(1);
                n_tests++;
                if (som !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_beep_end got %b exp 0", som);
                end
            end
        end
    endtask

    task automatic test_quick_start;
`ifdef INICIO_RAPIDO_EN
        enter_time(0, 0);
        pulse_iniciar;
        n_tests++;
        if ({rodando, disp} !== {1'b1, bcd(0, 30)}) begin
            n_fail++;
            $display("FAIL quick_zero got %b/%h exp 1/%h", rodando, disp, bcd(0, 30));
        end
        enter_time(1, 45);
        pulse_iniciar;
        pulse_iniciar;
        n_tests++;
        if (disp !== add30(1, 45)) begin
            n_fail++;
            $display("FAIL quick_add got %h exp %h", disp, add30(1, 45));
        end
        enter_time(99, 50);
        pulse_iniciar;
        pulse_iniciar;
        n_tests++;
        if (disp !== add30(99, 50)) begin
            n_fail++;
            $display("FAIL quick_sat got %h exp %h", disp, add30(99, 50));
        end
`else
        enter_time(0, 0);
        pulse_iniciar;
        n_tests++;
        if ({rodando, disp} !== {1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL quick_off_zero got %b/%h exp 0/0000", rodando, disp);
        end
        enter_time(1, 45);
        pulse_iniciar;
        pulse_iniciar;
        n_tests++;
        if (disp !== bcd(1, 45)) begin
            n_fail++;
            $display("FAIL quick_off_add got %h exp %h", disp, bcd(1, 45));
        end
`endif
    endtask

    initial begin
        test_reset;
        test_entry;
        test_countdown_basic;
        test_borrow;
        test_pause;
        test_priority;
        test_random_countdown;
        test_quick_start;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
